// File: rtl/qspi_pkg.sv
// Shared types and widths for the QSPI host slice.
// Holds the TX FSM state enum and the datapath widths.
`ifndef ENCRYPTER_QSPI_COUNT
`define ENCRYPTER_QSPI_COUNT 8
`endif

package qspi_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int BYTE_W          = 8;
    localparam int CNT_W           = 16;
    localparam int KEY_NIBBLES_DEF = `ENCRYPTER_QSPI_COUNT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROG,
        S_WAIT_KEY,
        S_KEY,
        S_GAP,
        S_WAIT_DATA,
        S_DATA,
        S_DRAIN
    } tx_state_e;

endpackage

// File: rtl/qspi_nibble_deser.sv
// Collector-side nibble reassembly into bytes.
// High nibble first; a half byte left by a falling rx_sending is dropped.
module qspi_nibble_deser
    import qspi_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    input  logic [NIBBLE_W-1:0] rx_data,
    input  logic                rx_sending,
    output logic                rx_ready,
    output logic [BYTE_W-1:0]   byte_out_data,
    output logic                byte_out_valid,
    input  logic                byte_out_ready,
    output logic [CNT_W-1:0]    rx_cnt,
    output logic                frag_err
);

    logic [NIBBLE_W-1:0] hi_q;
    logic                have_hi;
    logic                take;

    assign rx_ready = en && (!byte_out_valid || byte_out_ready);
    assign take     = rx_sending && rx_ready;
    assign frag_err = en && have_hi && !rx_sending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q           <= '0;
            have_hi        <= 1'b0;
            rx_cnt         <= '0;
            byte_out_data  <= '0;
            byte_out_valid <= 1'b0;
        end else if (clr) begin
            hi_q    <= '0;
            have_hi <= 1'b0;
            rx_cnt  <= '0;
        end else begin
            if (frag_err) begin
                have_hi <= 1'b0;
            end else if (take && !have_hi) begin
                hi_q    <= rx_data;
                have_hi <= 1'b1;
            end else if (take) begin
                have_hi <= 1'b0;
                rx_cnt  <= rx_cnt + CNT_W'(1);
            end
            // a freshly completed byte wins over the sink draining the old one
            if (take && have_hi) begin
                byte_out_data  <= {hi_q, rx_data};
                byte_out_valid <= 1'b1;
            end else if (byte_out_valid && byte_out_ready) begin
                byte_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/qspi_host.sv
// QSPI host: streams key then data nibbles to the parallelizer
// and reassembles collector nibbles into result bytes.
module qspi_host
    import qspi_pkg::*;
#(
    parameter int KEY_NIBBLES = KEY_NIBBLES_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [4*KEY_NIBBLES-1:0]    key,
    input  logic [BYTE_W-1:0]           byte_in_data,
    input  logic                        byte_in_valid,
    input  logic                        byte_in_last,
    output logic                        byte_in_ready,
    output logic                        prog,
    output logic [NIBBLE_W-1:0]         qspi_tx_data,
    output logic                        qspi_tx_sending,
    input  logic                        qspi_tx_ready,
    input  logic [NIBBLE_W-1:0]         qspi_rx_data,
    input  logic                        qspi_rx_sending,
    output logic                        qspi_rx_ready,
    output logic [BYTE_W-1:0]           byte_out_data,
    output logic                        byte_out_valid,
    input  logic                        byte_out_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int KEY_W = 4 * KEY_NIBBLES;
    localparam int KC_W  = $clog2(KEY_NIBBLES + 1);

    tx_state_e          state, nxt;
    logic [KEY_W-1:0]   key_sr;
    logic [KC_W-1:0]    key_cnt;
    logic               lo_q;
    logic [CNT_W-1:0]   tx_cnt;
    logic [CNT_W-1:0]   rx_cnt;
    logic               frag_err;

    logic key_load, key_shift, tx_inc, set_err, ph_lo, ph_hi;

    always_comb begin
        nxt           = state;
        prog          = 1'b0;
        qspi_tx_sending = 1'b0;
        qspi_tx_data  = '0;
        byte_in_ready = 1'b0;
        done          = 1'b0;
        key_load      = 1'b0;
        key_shift     = 1'b0;
        tx_inc        = 1'b0;
        set_err       = 1'b0;
        ph_lo         = 1'b0;
        ph_hi         = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    key_load = 1'b1;
                    nxt      = S_PROG;
                end
            end
            S_PROG: begin
                prog = 1'b1;
                nxt  = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                if (qspi_tx_ready) begin
                    qspi_tx_sending = 1'b1;
                    qspi_tx_data    = key_sr[KEY_W-1 -: NIBBLE_W];
                    key_shift       = 1'b1;
                    nxt = (KEY_NIBBLES == 1) ? S_GAP : S_KEY;
                end
            end
            // key nibbles are pushed blind, one per cycle
            S_KEY: begin
                qspi_tx_sending = 1'b1;
                qspi_tx_data    = key_sr[KEY_W-1 -: NIBBLE_W];
                key_shift       = 1'b1;
                if (key_cnt == KC_W'(KEY_NIBBLES - 1)) nxt = S_GAP;
            end
            S_GAP: begin
                nxt = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (qspi_tx_ready && byte_in_valid) begin
                    qspi_tx_sending = 1'b1;
                    qspi_tx_data    = byte_in_data[BYTE_W-1 -: NIBBLE_W];
                    ph_lo           = 1'b1;
                    nxt             = S_DATA;
                end
            end
            S_DATA: begin
                if (lo_q) begin
                    qspi_tx_sending = 1'b1;
                    qspi_tx_data    = byte_in_data[NIBBLE_W-1:0];
                    if (qspi_tx_ready) begin
                        byte_in_ready = 1'b1;
                        tx_inc        = 1'b1;
                        ph_hi         = 1'b1;
                        if (byte_in_last) nxt = S_DRAIN;
                    end
                end else if (!byte_in_valid) begin
                    set_err = 1'b1;
                    nxt     = S_DRAIN;
                end else begin
                    qspi_tx_sending = 1'b1;
                    qspi_tx_data    = byte_in_data[BYTE_W-1 -: NIBBLE_W];
                    if (qspi_tx_ready) ph_lo = 1'b1;
                end
            end
            S_DRAIN: begin
                if (rx_cnt == tx_cnt && !qspi_rx_sending && !byte_out_valid) begin
                    done = 1'b1;
                    nxt  = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            key_sr  <= '0;
            key_cnt <= '0;
            lo_q    <= 1'b0;
            tx_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            if (key_load) begin
                key_sr  <= key;
                key_cnt <= '0;
            end else if (key_shift) begin
                key_sr  <= key_sr << NIBBLE_W;
                key_cnt <= key_cnt + KC_W'(1);
            end
            if (ph_lo)      lo_q <= 1'b1;
            else if (ph_hi) lo_q <= 1'b0;
            if (key_load)    tx_cnt <= '0;
            else if (tx_inc) tx_cnt <= tx_cnt + CNT_W'(1);
            if (key_load)                 err <= 1'b0;
            else if (set_err || frag_err) err <= 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

    qspi_nibble_deser u_deser (
        .clk            (clk),
        .reset          (reset),
        .en             (busy),
        .clr            (key_load),
        .rx_data        (qspi_rx_data),
        .rx_sending     (qspi_rx_sending),
        .rx_ready       (qspi_rx_ready),
        .byte_out_data  (byte_out_data),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (byte_out_ready),
        .rx_cnt         (rx_cnt),
        .frag_err       (frag_err)
    );

endmodule

// File: tb/tb_qspi_host.sv
// Directed bench for qspi_host with TX-nibble and RX-byte scoreboards.
module tb_qspi_host;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] key;
    logic [7:0]  byte_in_data;
    logic        byte_in_valid;
    logic        byte_in_last;
    logic        byte_in_ready;
    logic        prog;
    logic [3:0]  qspi_tx_data;
    logic        qspi_tx_sending;
    logic        qspi_tx_ready;
    logic [3:0]  qspi_rx_data;
    logic        qspi_rx_sending;
    logic        qspi_rx_ready;
    logic [7:0]  byte_out_data;
    logic        byte_out_valid;
    logic        byte_out_ready;
    logic        busy;
    logic        done;
    logic        err;

    qspi_host #(.KEY_NIBBLES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .key             (key),
        .byte_in_data    (byte_in_data),
        .byte_in_valid   (byte_in_valid),
        .byte_in_last    (byte_in_last),
        .byte_in_ready   (byte_in_ready),
        .prog            (prog),
        .qspi_tx_data    (qspi_tx_data),
        .qspi_tx_sending (qspi_tx_sending),
        .qspi_tx_ready   (qspi_tx_ready),
        .qspi_rx_data    (qspi_rx_data),
        .qspi_rx_sending (qspi_rx_sending),
        .qspi_rx_ready   (qspi_rx_ready),
        .byte_out_data   (byte_out_data),
        .byte_out_valid  (byte_out_valid),
        .byte_out_ready  (byte_out_ready),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    logic [3:0] tx_q[$];
    logic [7:0] rxb_q[$];
    logic [8:0] src_q[$];
    logic [3:0] rx_q[$];

    logic       snap_prog, snap_sending, snap_bir, snap_bov;
    logic       snap_rx_ready, snap_busy, snap_err;
    logic [3:0] snap_tx;
    logic [7:0] snap_bod;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        byte_in_valid   = src_q.size() > 0;
        byte_in_data    = (src_q.size() > 0) ? src_q[0][7:0] : 8'h00;
        byte_in_last    = (src_q.size() > 0) ? src_q[0][8] : 1'b0;
        qspi_rx_sending = rx_q.size() > 0;
        qspi_rx_data    = (rx_q.size() > 0) ? rx_q[0] : 4'h0;
    endtask

    // one clock: observe mid-cycle, then update the sources after the edge
    task automatic step();
        logic       in_fire, rx_fire;
        logic [3:0] en;
        logic [7:0] eb;
        @(negedge clk);
        snap_prog     = prog;
        snap_sending  = qspi_tx_sending;
        snap_bir      = byte_in_ready;
        snap_bov      = byte_out_valid;
        snap_rx_ready = qspi_rx_ready;
        snap_busy     = busy;
        snap_err      = err;
        snap_tx       = qspi_tx_data;
        snap_bod      = byte_out_data;
        if (done) done_cnt++;
        in_fire = byte_in_valid && byte_in_ready;
        rx_fire = qspi_rx_sending && qspi_rx_ready;
        if (qspi_tx_sending && qspi_tx_ready) begin
            en = (tx_q.size() > 0) ? tx_q.pop_front() : 4'hx;
            check("tx_nibble", {28'h0, qspi_tx_data}, {28'h0, en});
        end
        if (byte_out_valid && byte_out_ready) begin
            eb = (rxb_q.size() > 0) ? rxb_q.pop_front() : 8'hxx;
            check("rx_byte", {24'h0, byte_out_data}, {24'h0, eb});
        end
        @(posedge clk);
        #1;
        if (in_fire) void'(src_q.pop_front());
        if (rx_fire) void'(rx_q.pop_front());
        drive();
    endtask

    task automatic run_key(input logic [31:0] k);
        for (int i = 7; i >= 0; i--) tx_q.push_back(k[4*i +: 4]);
        key   = k;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("prog_pulse", {31'h0, snap_prog}, 32'd1);
        check("busy_prog", {31'h0, snap_busy}, 32'd1);
        check("err_cleared", {31'h0, snap_err}, 32'd0);
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            start = 1'b0;
            check("key_send", {31'h0, snap_sending}, 32'd1);
        end
        check("prog_once", {31'h0, snap_prog}, 32'd0);
        step();
        check("key_gap", {31'h0, snap_sending}, 32'd0);
        check("key_all_sent", tx_q.size(), 32'd0);
    endtask

    task automatic wait_done();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 60 && done_cnt == d0; i++) step();
        check("done_pulse", done_cnt, d0 + 1);
        step();
        step();
        check("done_once", done_cnt, d0 + 1);
        check("idle_after", {31'h0, snap_busy}, 32'd0);
        check("sb_empty", tx_q.size() + rxb_q.size(), 32'd0);
    endtask

    function automatic logic [24:0] outs();
        return {prog, qspi_tx_sending, qspi_tx_data, byte_in_ready,
                qspi_rx_ready, byte_out_valid, byte_out_data, busy,
                done, err, 6'h0};
    endfunction

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        key            = '0;
        qspi_tx_ready  = 1'b1;
        byte_out_ready = 1'b0;
        drive();
        #1;
        check("reset_outs", {7'h0, outs()}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // session 1: key, stalled data, back-pressured RX
        run_key(32'hB4352B93);
        src_q.push_back({1'b0, 8'h48});
        src_q.push_back({1'b1, 8'h69});
        tx_q.push_back(4'h4);
        tx_q.push_back(4'h8);
        tx_q.push_back(4'h6);
        tx_q.push_back(4'h9);
        drive();
        step();
        check("hi_no_ready", {31'h0, snap_bir}, 32'd0);
        qspi_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_tx", {28'h0, snap_tx}, 32'h8);
            check("stall_send", {31'h0, snap_sending}, 32'd1);
            check("stall_bir", {31'h0, snap_bir}, 32'd0);
        end
        qspi_tx_ready = 1'b1;
        step();
        check("bir_lo1", {31'h0, snap_bir}, 32'd1);
        step();
        check("bir_hi2", {31'h0, snap_bir}, 32'd0);
        step();
        check("bir_lo2", {31'h0, snap_bir}, 32'd1);
        step();
        check("drain_quiet", {31'h0, snap_sending}, 32'd0);
        check("drain_busy", {31'h0, snap_busy}, 32'd1);
        rx_q.push_back(4'h3);
        rx_q.push_back(4'hA);
        rx_q.push_back(4'hF);
        rx_q.push_back(4'h0);
        rxb_q.push_back(8'h3A);
        rxb_q.push_back(8'hF0);
        drive();
        repeat (4) step();
        check("rx_held_valid", {31'h0, snap_bov}, 32'd1);
        check("rx_held_data", {24'h0, snap_bod}, 32'h3A);
        check("rx_blocked", {31'h0, snap_rx_ready}, 32'd0);
        check("no_early_done", done_cnt, 32'd0);
        byte_out_ready = 1'b1;
        wait_done();

        // session 2: fragmented RX nibble sets a sticky err
        run_key(32'h12345678);
        rx_q.push_back(4'h7);
        drive();
        repeat (4) step();
        check("frag_err", {31'h0, snap_err}, 32'd1);
        check("frag_no_out", {31'h0, snap_bov}, 32'd0);
        src_q.push_back({1'b1, 8'h5A});
        tx_q.push_back(4'h5);
        tx_q.push_back(4'hA);
        rx_q.push_back(4'h5);
        rx_q.push_back(4'hA);
        rxb_q.push_back(8'h5A);
        drive();
        wait_done();
        check("err_sticky", {31'h0, snap_err}, 32'd1);

        // session 3: source underflow mid-stream
        run_key(32'h9ABCDEF0);
        src_q.push_back({1'b0, 8'h48});
        tx_q.push_back(4'h4);
        tx_q.push_back(4'h8);
        drive();
        step();
        step();
        check("uf_bir", {31'h0, snap_bir}, 32'd1);
        step();
        check("uf_send", {31'h0, snap_sending}, 32'd0);
        step();
        check("uf_err", {31'h0, snap_err}, 32'd1);
        check("uf_quiet", {31'h0, snap_sending}, 32'd0);
        rx_q.push_back(4'h4);
        rx_q.push_back(4'h8);
        rxb_q.push_back(8'h48);
        drive();
        wait_done();

        // session 4: async reset in the middle of the key
        for (int i = 7; i >= 0; i--) tx_q.push_back(key[4*i +: 4]);
        key   = 32'hB4352B93;
        tx_q.delete();
        for (int i = 7; i >= 0; i--) tx_q.push_back(key[4*i +: 4]);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        repeat (4) step();
        check("pre_reset_send", {31'h0, qspi_tx_sending}, 32'd1);
        check("pre_reset_nib", {28'h0, qspi_tx_data}, 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outs", {7'h0, outs()}, 32'd0);
        tx_q.delete();
        @(posedge clk);
        #1;
        check("reset_held_outs", {7'h0, outs()}, 32'd0);
        reset = 1'b1;
        run_key(32'hB4352B93);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
